// File: rtl/accum_seq_pkg.sv
// Shared widths and sequencer state encoding for the accumulator job sequencer.
package accum_seq_pkg;

    localparam int DW = 3;  // operand width
    localparam int SW = 2;  // op-select width
    localparam int RW = 6;  // datapath result width
    localparam int CW = 4;  // run-count width

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/accum_seq_arbiter_rr_arb2.sv
// Two-input round-robin grant. On a tie the requester not served last wins;
// the last-served pointer only moves when a grant is actually accepted.
module rr_arb2 (
    input  logic       clk,
    input  logic       i_rst,
    input  logic [1:0] i_valid,
    input  logic       i_accept,
    output logic [1:0] o_grant,
    output logic       o_grant_id
);

    logic last_q, last_d;

    // Grant selection and pointer next-state
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = last_q ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
        o_grant_id = o_grant[1];
        last_d     = last_q;
        if (i_accept) last_d = o_grant[1];
    end

    // Pointer starts at 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (i_rst) last_q <= 1'b1;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/accum_seq_arbiter.sv
// Time-shares one accumulator datapath between two requesters. Each job is
// granted round-robin, the datapath is cleared, run for cnt ops, the result
// and sticky overflow are captured and returned on a valid/ready channel.
module accum_seq_arbiter
    import accum_seq_pkg::*;
#(
    parameter int DW = accum_seq_pkg::DW,
    parameter int SW = accum_seq_pkg::SW,
    parameter int RW = accum_seq_pkg::RW,
    parameter int CW = accum_seq_pkg::CW
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic [1:0]      i_req_valid,
    output logic [1:0]      o_req_ready,
    input  logic [2*DW-1:0] i_req_data1,
    input  logic [2*DW-1:0] i_req_data2,
    input  logic [2*SW-1:0] i_req_sel,
    input  logic [2*CW-1:0] i_req_cnt,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic            o_rsp_id,
    output logic [RW-1:0]   o_rsp_data,
    output logic            o_rsp_ovf,
    output logic [DW-1:0]   o_dp_data1,
    output logic [DW-1:0]   o_dp_data2,
    output logic [SW-1:0]   o_dp_sel,
    output logic            o_dp_rst_n,
    input  logic [RW-1:0]   i_dp_data,
    input  logic            i_dp_overflow
);

    state_t          state_q, state_d;
    logic [DW-1:0]   d1_q, d1_d, d2_q, d2_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   run_q, run_d;
    logic            id_q, id_d;
    logic            ovf_q, ovf_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            rsp_id_q, rsp_id_d;
    logic [RW-1:0]   rsp_data_q, rsp_data_d;
    logic            rsp_ovf_q, rsp_ovf_d;

    logic [1:0]      arb_valid;
    logic [1:0]      grant;
    logic            grant_id;
    logic            accept;
    logic            dp_active;

    // Requests are only visible to the arbiter while idle and out of reset
    assign arb_valid   = (state_q == ST_IDLE && !i_rst) ? i_req_valid : 2'b00;
    assign o_req_ready = grant;
    assign accept      = |grant;

    rr_arb2 u_arb (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_valid    (arb_valid),
        .i_accept   (accept),
        .o_grant    (grant),
        .o_grant_id (grant_id)
    );

    // Datapath drive: job values only while the job owns the datapath
    assign dp_active  = (state_q == ST_CLEAR) || (state_q == ST_RUN) ||
                        (state_q == ST_CAPTURE);
    assign o_dp_data1 = dp_active ? d1_q  : '0;
    assign o_dp_data2 = dp_active ? d2_q  : '0;
    assign o_dp_sel   = dp_active ? sel_q : '0;
    assign o_dp_rst_n = (state_q == ST_RUN);

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_id    = rsp_id_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_ovf   = rsp_ovf_q;

    // Next-state, job latch, run counter, sticky overflow and response capture
    always_comb begin
        state_d     = state_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        id_d        = id_q;
        run_d       = run_q;
        ovf_d       = ovf_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_ovf_d   = rsp_ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    id_d = grant_id;
                    if (grant_id) begin
                        d1_d  = i_req_data1[DW +: DW];
                        d2_d  = i_req_data2[DW +: DW];
                        sel_d = i_req_sel[SW +: SW];
                        cnt_d = i_req_cnt[CW +: CW];
                    end else begin
                        d1_d  = i_req_data1[0 +: DW];
                        d2_d  = i_req_data2[0 +: DW];
                        sel_d = i_req_sel[0 +: SW];
                        cnt_d = i_req_cnt[0 +: CW];
                    end
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                run_d   = '0;
                ovf_d   = 1'b0;
                state_d = (cnt_q != '0) ? ST_RUN : ST_CAPTURE;
            end
            ST_RUN: begin
                run_d = run_q + CW'(1);
                // First RUN cycle still shows the cleared flag, not an op
                if (run_q != '0) ovf_d = ovf_q | i_dp_overflow;
                if (run_q == cnt_q - CW'(1)) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                rsp_data_d  = i_dp_data;
                rsp_ovf_d   = ovf_q | i_dp_overflow;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight job
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            d1_q        <= '0;
            d2_q        <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            id_q        <= 1'b0;
            run_q       <= '0;
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            run_q       <= run_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

endmodule

// File: doc/accum_seq_arbiter.md
Name: accum_seq_arbiter

Overview:
- Shares the 6-bit accumulator datapath (3-bit operands, 2-bit op select, active-low clear, 6-bit result plus overflow) between two requesters.
- Per job: grants one requester by round-robin, clears the datapath, runs it for a requested number of cycles, captures the result and a sticky overflow, and returns them on a valid/ready response channel.
- Sits between the requester logic and the accumulator; the sequencer is the only driver of the datapath inputs.

Parameters:
- DW, 3, operand width (i_data1/i_data2 of the datapath).
- SW, 2, op-select width.
- RW, 6, datapath result width.
- CW, 4, run-count width; a job runs 0..2^CW-1 datapath cycles.

Ports:
- clk  in  1  system clock, rising edge.
- i_rst  in  1  reset: synchronous, active-high; single clock domain (clk).
- i_req_valid  in  2  per-requester job valid (bit i = requester i).
- o_req_ready  out  2  per-requester accept; at most one bit high.
- i_req_data1  in  2*DW  operand A per requester ({req1,req0}).
- i_req_data2  in  2*DW  operand B per requester.
- i_req_sel  in  2*SW  op select per requester.
- i_req_cnt  in  2*CW  run cycles per requester.
- o_rsp_valid  out  1  result valid.
- i_rsp_ready  in  1  result accept.
- o_rsp_id  out  1  requester index of the result.
- o_rsp_data  out  RW  captured result.
- o_rsp_ovf  out  1  sticky overflow over the run.
- o_dp_data1  out  DW  to datapath.
- o_dp_data2  out  DW  to datapath.
- o_dp_sel  out  SW  to datapath.
- o_dp_rst_n  out  1  datapath clear, active-low.
- i_dp_data  in  RW  datapath registered result.
- i_dp_overflow  in  1  datapath registered overflow.

Behaviour:
- Datapath contract:
  - On an edge with o_dp_rst_n=0 the datapath clears to 0.
  - Each edge with o_dp_rst_n=1 performs one op; i_dp_data/i_dp_overflow are registered.
- FSM states: IDLE, CLEAR, RUN, CAPTURE, RESP.
- IDLE:
  - Grant = round-robin over i_req_valid; on a tie, grant the requester not served last; with one valid, grant it.
  - o_req_ready = grant, combinational, asserted only in IDLE.
  - On handshake, latch data1/data2/sel/cnt/id and update the last-served pointer; go to CLEAR.
- CLEAR: 1 cycle, o_dp_rst_n=0. Next state RUN if cnt≠0, else CAPTURE.
- RUN:
  - o_dp_rst_n=1, counter counts cnt cycles; leave after the cnt-th cycle.
  - Sticky ovf |= i_dp_overflow each RUN cycle after the first.
- CAPTURE:
  - 1 cycle, o_dp_rst_n=0; i_dp_data holds exactly cnt ops.
  - Register o_rsp_data = i_dp_data and ovf |= i_dp_overflow; go to RESP.
- RESP:
  - o_rsp_valid=1; data/id/ovf held stable until i_rsp_ready.
  - On handshake, go to IDLE; o_rsp_valid drops the next cycle.
- o_dp_data1/2 and o_dp_sel: the latched job values from CLEAR through CAPTURE; 0 in IDLE and RESP.
- o_dp_rst_n: 0 in every state except RUN.
- Latency: o_rsp_valid rises cnt+2 cycles after the accept edge. Minimum one IDLE cycle between jobs.
- cnt=0: result 0, ovf 0.
- Requests arriving outside IDLE wait; no request is dropped. A requester may change its inputs only after its ready handshake.
- Reset (any state, synchronous):
  - Next state IDLE; o_req_ready=0 during reset.
  - o_rsp_valid=0, o_rsp_data=0, o_rsp_id=0, o_rsp_ovf=0.
  - o_dp_data1/2=0, o_dp_sel=0, o_dp_rst_n=0.
  - Last-served pointer = 1, so requester 0 wins the first tie.
  - An in-flight job is discarded.

Decomposition:
- Package accum_seq_pkg holds:
  - state enum/localparams (IDLE..RESP);
  - width defaults DW/SW/RW/CW.
- One sub-module, rr_arb2: two-input round-robin grant with last-served pointer and update-on-accept.

Test Plan:
Bench datapath stub: sel0 acc+=data1; sel1 acc+=data2; sel2 acc+=data1+data2; sel3 acc-=data1; 6-bit wrap sets overflow.
1. Single job: req0 data1=1, sel0, cnt=5 -> o_rsp_valid 7 cycles after accept; data=5, id=0, ovf=0.
2. Tie after reset: both valid (req1: data2=3, sel1, cnt=2) -> req0 granted first, then req1 with data=6, id=1; a third tie then grants req0.
3. Overflow: req1 data1=7, data2=7, sel2, cnt=5 (70 wraps at 64) -> data=6, ovf=1; next job without overflow reports ovf=0.
4. Back-pressure: i_rsp_ready=0 for 10 cycles -> response stable, o_req_ready=0 throughout, no datapath activity.
5. cnt=0 and sel3 underflow (data1=1, cnt=1) -> responses 0/ovf0 and 63/ovf1.
6. i_rst asserted mid-RUN -> next cycle IDLE, all outputs 0, o_dp_rst_n=0; a fresh job then completes correctly.
